// File: rtl/rvvi_pkg.sv
// rtl/rvvi_pkg.sv - shared record type and constants for the RVVI retire serializer
package rvvi_pkg;

  localparam int RVVI_DROP_W   = 16;
  localparam int RVVI_ILEN_MAX = 64;
  localparam int RVVI_XLEN_MAX = 64;

  // Insn and PC are sized to the widest supported core; narrower values are zero-extended.
  typedef struct packed {
    logic [63:0]              order;
    logic [RVVI_ILEN_MAX-1:0] insn;
    logic [RVVI_XLEN_MAX-1:0] pc;
    logic                     trap;
    logic [1:0]               mode;
  } rvvi_retire_t;

  // Saturating add used by the drop counter.
  function automatic logic [RVVI_DROP_W-1:0] rvvi_sat_add(input logic [RVVI_DROP_W-1:0] a,
                                                          input logic [31:0] b);
    logic [32:0] s;
    s = 33'(a) + 33'(b);
    if (s > 33'((1 << RVVI_DROP_W) - 1)) return '1;
    return s[RVVI_DROP_W-1:0];
  endfunction

endpackage

// File: rtl/rvvi_hart_fifo.sv
// rtl/rvvi_hart_fifo.sv - per-hart FIFO, up to RETIRE writes and one read per cycle
module rvvi_hart_fifo
  import rvvi_pkg::*;
#(
  parameter int RETIRE = 1,
  parameter int DEPTH  = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [RETIRE-1:0]             wr_valid,
  input  rvvi_retire_t [RETIRE-1:0]     wr_data,
  input  logic                          rd_en,
  output rvvi_retire_t                  rd_data,
  output logic [$clog2(DEPTH):0]        count
);

  localparam int AW = $clog2(DEPTH);

  rvvi_retire_t    mem_q [DEPTH];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [AW:0]     count_q;
  logic [AW-1:0]   slot [RETIRE];
  logic [AW:0]     n_push;

  // Valid lanes are packed into consecutive slots in lane order, skipping holes.
  always_comb begin
    n_push = '0;
    for (int k = 0; k < RETIRE; k++) begin
      slot[k] = wr_ptr_q + n_push[AW-1:0];
      if (wr_valid[k]) n_push = n_push + (AW+1)'(1);
    end
  end

  // Storage: contents are left as-is on reset, the pointers make them unreachable.
  always_ff @(posedge clk) begin
    for (int k = 0; k < RETIRE; k++) begin
      if (wr_valid[k]) mem_q[slot[k]] <= wr_data[k];
    end
  end

  // Pointers wrap naturally modulo DEPTH; occupancy tracks pushes minus pops.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_q + n_push[AW-1:0];
      if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q  <= count_q + n_push - (AW+1)'(rd_en);
    end
  end

  assign rd_data = mem_q[rd_ptr_q];
  assign count   = count_q;

endmodule

// File: rtl/rvvi_retire_serializer.sv
// rtl/rvvi_retire_serializer.sv - multi-hart retire lanes into one record stream; optional RVVI_ORDER_CHECK_EN
module rvvi_retire_serializer
  import rvvi_pkg::*;
#(
  parameter int ILEN   = 32,
  parameter int XLEN   = 32,
  parameter int NHART  = 1,
  parameter int RETIRE = 1,
  parameter int DEPTH  = 8
) (
  input  logic                                     clk,
  input  logic                                     rst,
  input  logic [NHART-1:0][RETIRE-1:0]             in_valid,
  input  logic [NHART-1:0][RETIRE-1:0][63:0]       in_order,
  input  logic [NHART-1:0][RETIRE-1:0][ILEN-1:0]   in_insn,
  input  logic [NHART-1:0][RETIRE-1:0][XLEN-1:0]   in_pc,
  input  logic [NHART-1:0][RETIRE-1:0]             in_trap,
  input  logic [NHART-1:0][RETIRE-1:0][1:0]        in_mode,
  output logic [NHART-1:0]                         in_ready,
  output logic                                     out_valid,
  input  logic                                     out_ready,
  output logic [((NHART > 1) ? $clog2(NHART) : 1)-1:0] out_hart,
  output rvvi_retire_t                             out_rec,
  output logic [NHART-1:0]                         ovf,
  output logic [RVVI_DROP_W-1:0]                   drop_cnt,
  output logic [NHART-1:0]                         order_err
);

  localparam int HW = (NHART > 1) ? $clog2(NHART) : 1;
  localparam int CW = $clog2(DEPTH) + 1;

  rvvi_retire_t [RETIRE-1:0] wr_data [NHART];
  logic [RETIRE-1:0]         wr_valid [NHART];
  rvvi_retire_t              rd_data [NHART];
  logic [CW-1:0]             count [NHART];
  logic [NHART-1:0]          rd_en;
  logic [NHART-1:0]          nonempty;
  logic [NHART-1:0]          gap;
  logic [NHART-1:0]          ord_bad;
  logic [NHART-1:0]          drop_hit;
  logic [31:0]               drop_sum;

  logic [HW-1:0]             rr_q;
  logic [HW-1:0]             grant_q;
  logic                      lock_q;
  logic [NHART-1:0]          ovf_q;
  logic [NHART-1:0]          order_err_q;
  logic [RVVI_DROP_W-1:0]    drop_q;

  logic [HW-1:0]             sel;
  logic [HW-1:0]             cur;
  logic                      any_ne;
  logic                      pop;
  int                        arb_idx;

  // Acceptance, record packing, contiguity and drop accounting per hart.
  always_comb begin
    drop_sum = '0;
    for (int h = 0; h < NHART; h++) begin
      in_ready[h] = !rst && (count[h] <= CW'(DEPTH - RETIRE));
      nonempty[h] = (count[h] != '0);
      wr_valid[h] = in_ready[h] ? in_valid[h] : '0;
      gap[h]      = 1'b0;
      drop_hit[h] = 1'b0;
      for (int k = 0; k < RETIRE; k++) begin
        wr_data[h][k]       = '0;
        wr_data[h][k].order = in_order[h][k];
        wr_data[h][k].insn  = RVVI_ILEN_MAX'(in_insn[h][k]);
        wr_data[h][k].pc    = RVVI_XLEN_MAX'(in_pc[h][k]);
        wr_data[h][k].trap  = in_trap[h][k];
        wr_data[h][k].mode  = in_mode[h][k];
        if (k > 0 && in_valid[h][k] && !in_valid[h][k-1]) gap[h] = 1'b1;
        if (!rst && !in_ready[h] && in_valid[h][k]) begin
          drop_hit[h] = 1'b1;
          drop_sum    = drop_sum + 32'd1;
        end
      end
    end
  end

  genvar gh;
  generate
    for (gh = 0; gh < NHART; gh++) begin : g_hart
      rvvi_hart_fifo #(
        .RETIRE (RETIRE),
        .DEPTH  (DEPTH)
      ) u_fifo (
        .clk      (clk),
        .rst      (rst),
        .wr_valid (wr_valid[gh]),
        .wr_data  (wr_data[gh]),
        .rd_en    (rd_en[gh]),
        .rd_data  (rd_data[gh]),
        .count    (count[gh])
      );
    end
  endgenerate

  // Round-robin pick starting at rr_q; a stalled grant stays locked until accepted.
  always_comb begin
    sel     = rr_q;
    any_ne  = 1'b0;
    arb_idx = 0;
    for (int i = 0; i < NHART; i++) begin
      arb_idx = (int'(rr_q) + i) % NHART;
      if (!any_ne && nonempty[arb_idx]) begin
        any_ne = 1'b1;
        sel    = HW'(arb_idx);
      end
    end
    cur       = lock_q ? grant_q : sel;
    out_valid = lock_q || any_ne;
    out_hart  = out_valid ? cur : '0;
    out_rec   = out_valid ? rd_data[cur] : '0;
    pop       = out_valid && out_ready;
    rd_en     = '0;
    if (pop) rd_en[cur] = 1'b1;
  end

  // Arbiter pointer, grant lock and sticky status.
  always_ff @(posedge clk) begin
    if (rst) begin
      rr_q        <= '0;
      grant_q     <= '0;
      lock_q      <= 1'b0;
      ovf_q       <= '0;
      order_err_q <= '0;
      drop_q      <= '0;
    end else begin
      if (pop) rr_q <= (cur == HW'(NHART - 1)) ? '0 : cur + HW'(1);
      grant_q     <= cur;
      lock_q      <= out_valid && !out_ready;
      ovf_q       <= ovf_q | drop_hit;
      order_err_q <= order_err_q | gap | ord_bad;
      drop_q      <= rvvi_sat_add(drop_q, drop_sum);
    end
  end

`ifdef RVVI_ORDER_CHECK_EN
  logic [63:0]      exp_q [NHART];
  logic [63:0]      exp_d [NHART];
  logic [NHART-1:0] have_q;
  logic [NHART-1:0] have_d;
  logic [63:0]      oc_base;
  int               oc_j;

  // Accepted lanes must count up from the expected order; expected resyncs to the last one.
  always_comb begin
    oc_base = '0;
    oc_j    = 0;
    for (int h = 0; h < NHART; h++) begin
      ord_bad[h] = 1'b0;
      exp_d[h]   = exp_q[h];
      have_d[h]  = have_q[h];
      oc_base    = exp_q[h];
      oc_j       = 0;
      if (in_ready[h]) begin
        for (int k = 0; k < RETIRE; k++) begin
          if (in_valid[h][k]) begin
            if (!have_q[h] && oc_j == 0) oc_base = in_order[h][k];
            if (in_order[h][k] != oc_base + 64'(oc_j)) ord_bad[h] = 1'b1;
            exp_d[h]  = in_order[h][k] + 64'd1;
            have_d[h] = 1'b1;
            oc_j      = oc_j + 1;
          end
        end
      end
    end
  end

  // Expected-order registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      have_q <= '0;
      for (int h = 0; h < NHART; h++) exp_q[h] <= '0;
    end else begin
      have_q <= have_d;
      for (int h = 0; h < NHART; h++) exp_q[h] <= exp_d[h];
    end
  end
`else
  assign ord_bad = '0;
`endif

  assign ovf       = ovf_q;
  assign order_err = order_err_q;
  assign drop_cnt  = drop_q;

endmodule

// File: tb/tb_rvvi_retire_serializer.sv
// tb/tb_rvvi_retire_serializer.sv - self-checking bench for rvvi_retire_serializer
module tb_rvvi_retire_serializer;
  import rvvi_pkg::*;

  localparam int NH = 3;
  localparam int RT = 2;
  localparam int DP = 4;
`ifdef RVVI_ORDER_CHECK_EN
  localparam bit OCHK = 1'b1;
`else
  localparam bit OCHK = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NH-1:0][RT-1:0]        in_valid;
  logic [NH-1:0][RT-1:0][63:0]  in_order;
  logic [NH-1:0][RT-1:0][31:0]  in_insn;
  logic [NH-1:0][RT-1:0][31:0]  in_pc;
  logic [NH-1:0][RT-1:0]        in_trap;
  logic [NH-1:0][RT-1:0][1:0]   in_mode;
  logic [NH-1:0]                in_ready;
  logic                         out_valid;
  logic                         out_ready;
  logic [1:0]                   out_hart;
  rvvi_retire_t                 out_rec;
  logic [NH-1:0]                ovf;
  logic [15:0]                  drop_cnt;
  logic [NH-1:0]                order_err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  rvvi_retire_serializer #(
    .ILEN(32), .XLEN(32), .NHART(NH), .RETIRE(RT), .DEPTH(DP)
  ) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_order(in_order), .in_insn(in_insn),
    .in_pc(in_pc), .in_trap(in_trap), .in_mode(in_mode), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_hart(out_hart), .out_rec(out_rec),
    .ovf(ovf), .drop_cnt(drop_cnt), .order_err(order_err)
  );

  // Reference model: one queue of records per hart plus sticky flags.
  rvvi_retire_t mq [NH][$];
  int           m_rr;
  bit           m_lock;
  int           m_grant;
  bit [NH-1:0]  m_ovf;
  bit [NH-1:0]  m_err;
  int           m_drop;
  logic [63:0]  m_exp [NH];
  bit           m_have [NH];
  logic [63:0]  next_ord [NH];

  typedef struct {
    logic       r;
    logic [2:0] push;
    logic       rdy;
    logic       ev;
    int         eh;
  } vec_t;
  vec_t tbl [15];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic rvvi_retire_t mk(input int h, input int k);
    rvvi_retire_t r;
    r       = '0;
    r.order = in_order[h][k];
    r.insn  = 64'(in_insn[h][k]);
    r.pc    = 64'(in_pc[h][k]);
    r.trap  = in_trap[h][k];
    r.mode  = in_mode[h][k];
    return r;
  endfunction

  function automatic int m_pick();
    if (m_lock) return m_grant;
    for (int i = 0; i < NH; i++) begin
      if (mq[(m_rr + i) % NH].size() > 0) return (m_rr + i) % NH;
    end
    return -1;
  endfunction

  task automatic model_reset();
    for (int h = 0; h < NH; h++) begin
      mq[h].delete();
      m_exp[h]  = '0;
      m_have[h] = 1'b0;
    end
    m_rr = 0; m_lock = 1'b0; m_grant = 0; m_ovf = '0; m_err = '0; m_drop = 0;
  endtask

  task automatic set_idle();
    in_valid = '0;
  endtask

  task automatic drive(input int h, input int n);
    for (int k = 0; k < RT; k++) begin
      in_valid[h][k] = (k < n);
      in_order[h][k] = next_ord[h] + 64'(k);
      in_insn[h][k]  = $urandom;
      in_pc[h][k]    = $urandom;
      in_trap[h][k]  = 1'($urandom);
      in_mode[h][k]  = 2'($urandom);
    end
    next_ord[h] = next_ord[h] + 64'(n);
  endtask

  // Compare DUT against the model, clock once, then advance the model.
  task automatic cycle();
    int g, n, j;
    bit rdy [NH];
    rvvi_retire_t r;
    logic [63:0] base;
    #1;
    g = m_pick();
    chk("out_valid", 64'(out_valid), 64'(g >= 0));
    if (g >= 0) begin
      chk("out_hart", 64'(out_hart), 64'(g));
      chk("rec_order", out_rec.order, mq[g][0].order);
      chk("rec_insn", out_rec.insn, mq[g][0].insn);
      chk("rec_pc", out_rec.pc, mq[g][0].pc);
      chk("rec_tm", 64'({out_rec.trap, out_rec.mode}), 64'({mq[g][0].trap, mq[g][0].mode}));
    end else begin
      chk("rec_idle_zero", 64'(out_rec == '0), 64'(1));
    end
    for (int h = 0; h < NH; h++) begin
      rdy[h] = (DP - mq[h].size()) >= RT;
      chk("in_ready", 64'(in_ready[h]), 64'(!rst && rdy[h]));
    end
    chk("ovf", 64'(ovf), 64'(m_ovf));
    chk("order_err", 64'(order_err), 64'(m_err));
    chk("drop_cnt", 64'(drop_cnt), 64'(m_drop));
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      if (g >= 0 && out_ready) begin
        void'(mq[g].pop_front());
        m_rr = (g + 1) % NH;
      end
      m_lock  = (g >= 0) && !out_ready;
      m_grant = g;
      for (int h = 0; h < NH; h++) begin
        for (int k = 1; k < RT; k++) if (in_valid[h][k] && !in_valid[h][k-1]) m_err[h] = 1'b1;
        n = 0; j = 0;
        base = m_exp[h];
        for (int k = 0; k < RT; k++) begin
          if (in_valid[h][k]) begin
            if (rdy[h]) begin
              r = mk(h, k);
              if (OCHK) begin
                if (!m_have[h] && j == 0) base = r.order;
                if (r.order != base + 64'(j)) m_err[h] = 1'b1;
                m_exp[h]  = r.order + 64'd1;
                m_have[h] = 1'b1;
              end
              mq[h].push_back(r);
              j++;
            end else begin
              n++;
            end
          end
        end
        if (n > 0) begin
          m_ovf[h] = 1'b1;
          m_drop   = (m_drop + n > 65535) ? 65535 : m_drop + n;
        end
      end
    end
    #1;
  endtask

  task automatic rst_pulse();
    rst = 1'b1;
    set_idle();
    #1;
    chk("in_ready_in_rst", 64'(in_ready), 64'(0));
    cycle();
    rst = 1'b0;
    for (int h = 0; h < NH; h++) next_ord[h] = '0;
    #1;
    chk("post_rst_valid", 64'(out_valid), 64'(0));
    chk("post_rst_drop", 64'(drop_cnt), 64'(0));
    chk("post_rst_ready", 64'(in_ready), 64'(3'b111));
  endtask

  initial begin
    in_valid = '0; in_order = '0; in_insn = '0; in_pc = '0; in_trap = '0; in_mode = '0;
    out_ready = 1'b0;
    for (int h = 0; h < NH; h++) next_ord[h] = '0;
    model_reset();

    tbl[0]  = '{r:0, push:3'b111, rdy:1, ev:0, eh:0};
    tbl[1]  = '{r:0, push:3'b000, rdy:1, ev:1, eh:0};
    tbl[2]  = '{r:0, push:3'b000, rdy:1, ev:1, eh:1};
    tbl[3]  = '{r:0, push:3'b000, rdy:1, ev:1, eh:2};
    tbl[4]  = '{r:0, push:3'b000, rdy:1, ev:1, eh:0};
    tbl[5]  = '{r:0, push:3'b000, rdy:1, ev:1, eh:1};
    tbl[6]  = '{r:0, push:3'b000, rdy:1, ev:1, eh:2};
    tbl[7]  = '{r:0, push:3'b000, rdy:1, ev:0, eh:0};
    tbl[8]  = '{r:1, push:3'b000, rdy:1, ev:0, eh:0};
    tbl[9]  = '{r:0, push:3'b101, rdy:1, ev:0, eh:0};
    tbl[10] = '{r:0, push:3'b000, rdy:1, ev:1, eh:0};
    tbl[11] = '{r:0, push:3'b000, rdy:1, ev:1, eh:2};
    tbl[12] = '{r:0, push:3'b000, rdy:1, ev:1, eh:0};
    tbl[13] = '{r:0, push:3'b000, rdy:1, ev:1, eh:2};
    tbl[14] = '{r:0, push:3'b000, rdy:1, ev:0, eh:0};

    @(posedge clk); #1;
    cycle();
    rst_pulse();

    // One-cycle latency, lane 0 first.
    out_ready = 1'b1;
    drive(0, 2);
    cycle();
    set_idle();
    #1;
    chk("lat_valid", 64'(out_valid), 64'(1));
    chk("lat_order0", out_rec.order, 64'd0);
    cycle();
    chk("lat_order1", out_rec.order, 64'd1);
    cycle();
    chk("lat_empty", 64'(out_valid), 64'(0));

    // Round-robin table.
    rst_pulse();
    for (int i = 0; i < 15; i++) begin
      rst = tbl[i].r;
      set_idle();
      for (int h = 0; h < NH; h++) if (tbl[i].push[h]) drive(h, 2);
      out_ready = tbl[i].rdy;
      #1;
      chk("tbl_valid", 64'(out_valid), 64'(tbl[i].ev));
      if (tbl[i].ev) chk("tbl_hart", 64'(out_hart), 64'(tbl[i].eh));
      cycle();
    end
    rst = 1'b0;

    // Overflow on a DEPTH=4 FIFO with the consumer stalled.
    rst_pulse();
    out_ready = 1'b0;
    drive(0, 2);
    cycle();
    drive(0, 2);
    cycle();
    chk("ovf_ready_low", 64'(in_ready[0]), 64'(0));
    drive(0, 2);
    cycle();
    set_idle();
    #1;
    chk("ovf_flag", 64'(ovf), 64'(3'b001));
    chk("ovf_drop", 64'(drop_cnt), 64'(2));

    // Output holds for 5 stalled cycles while other harts fill.
    for (int i = 0; i < 5; i++) begin
      set_idle();
      drive(1, 1);
      drive(2, 1);
      #1;
      chk("hold_hart", 64'(out_hart), 64'(0));
      chk("hold_order", out_rec.order, 64'd0);
      cycle();
    end
    set_idle();
    out_ready = 1'b1;
    cycle();
    chk("after_hold_hart", 64'(out_hart), 64'(1));
    cycle();

    // Reset with records queued restarts the arbiter at hart 0.
    rst_pulse();
    drive(0, 1);
    drive(2, 1);
    cycle();
    set_idle();
    #1;
    chk("rst_rr_first", 64'(out_hart), 64'(0));
    cycle();
    chk("rst_rr_second", 64'(out_hart), 64'(2));
    cycle();

    // Order gap 0,1,3,4 on hart 0.
    rst_pulse();
    set_idle();
    in_valid[0] = 2'b01; in_order[0][0] = 64'd0; cycle();
    in_order[0][0] = 64'd1; cycle();
    #1; chk("ord_no_err", 64'(order_err), 64'(0));
    in_order[0][0] = 64'd3; cycle();
    #1; chk("ord_gap", 64'(order_err[0]), 64'(OCHK));
    in_order[0][0] = 64'd4; cycle();
    #1; chk("ord_after", 64'(order_err[0]), 64'(OCHK));
    set_idle();
    cycle();

    // Non-contiguous lanes on hart 1.
    rst_pulse();
    in_valid[1] = 2'b10; in_order[1][1] = 64'd0;
    cycle();
    set_idle();
    #1;
    chk("gap_lanes", 64'(order_err), 64'(3'b010));
    cycle();
    cycle();

    // Randomized traffic against the model.
    rst_pulse();
    for (int i = 0; i < 3000; i++) begin
      rst = ($urandom_range(199) == 0);
      set_idle();
      for (int h = 0; h < NH; h++) begin
        if ($urandom_range(19) == 0) next_ord[h] = next_ord[h] + 64'd1;
        if ($urandom_range(2) != 0) drive(h, $urandom_range(2));
        if ($urandom_range(40) == 0) in_valid[h] = 2'b10;
      end
      out_ready = ($urandom_range(9) < (((i % 400) < 200) ? 8 : 3));
      cycle();
    end
    rst = 1'b0;
    set_idle();
    cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
